// File: rtl/throughput_reporter.sv
// throughput_reporter: converts each completed window's op count to decimal
// and streams "OPS dddddddddd\r\n" to a byte-wide valid/ready sink.
`default_nettype none

module throughput_reporter #(
  parameter int COUNT_WIDTH = 32,
  parameter int DIGITS      = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_window_done,
  input  logic [COUNT_WIDTH-1:0] i_ops_result,
  output logic [7:0]             o_tx_data,
  output logic                   o_tx_valid,
  input  logic                   i_tx_ready,
  output logic                   o_busy,
  output logic [COUNT_WIDTH-1:0] o_peak_ops,
  output logic [7:0]             o_dropped_count
);

  localparam int BCD_W    = 4 * DIGITS;
  localparam int CNT_W    = $clog2(COUNT_WIDTH + 1);
  localparam int IDX_W    = $clog2(DIGITS + 7);
  localparam int LAST_IDX = DIGITS + 5;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;

  logic [1:0]             r_state;
  logic [COUNT_WIDTH-1:0] r_bin;
  logic [BCD_W-1:0]       r_bcd;
  logic [CNT_W-1:0]       r_cnt;
  logic [IDX_W-1:0]       r_idx;
  logic [7:0]             r_tx_data;
  logic                   r_tx_valid;
  logic                   r_busy;
  logic [COUNT_WIDTH-1:0] r_peak;
  logic [7:0]             r_dropped;

  logic [BCD_W-1:0]       w_bcd_adj;
  logic [BCD_W-1:0]       w_bcd_next;
  logic [COUNT_WIDTH-1:0] w_bin_next;
  logic [IDX_W-1:0]       w_next_idx;
  logic [7:0]             w_next_byte;
  logic                   w_xfer;
  logic                   w_last_step;

  always_comb begin
    w_bcd_adj = r_bcd;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_bcd[4*d +: 4] >= 4'd5) begin
        w_bcd_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
      end
    end
  end

  assign w_bcd_next  = {w_bcd_adj[BCD_W-2:0], r_bin[COUNT_WIDTH-1]};
  assign w_bin_next  = {r_bin[COUNT_WIDTH-2:0], 1'b0};
  assign w_last_step = (r_cnt == CNT_W'(COUNT_WIDTH - 1));
  assign w_xfer      = r_tx_valid && i_tx_ready;
  assign w_next_idx  = r_idx + 1'b1;

  // Byte that follows the current one; digits are emitted most significant first.
  always_comb begin
    w_next_byte = 8'h00;
    if (w_next_idx == IDX_W'(1)) w_next_byte = 8'h50;
    if (w_next_idx == IDX_W'(2)) w_next_byte = 8'h53;
    if (w_next_idx == IDX_W'(3)) w_next_byte = 8'h20;
    for (int d = 0; d < DIGITS; d++) begin
      if (w_next_idx == IDX_W'(DIGITS + 3 - d)) w_next_byte = {4'h3, r_bcd[4*d +: 4]};
    end
    if (w_next_idx == IDX_W'(LAST_IDX - 1)) w_next_byte = 8'h0D;
    if (w_next_idx == IDX_W'(LAST_IDX))     w_next_byte = 8'h0A;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_bin      <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_window_done) begin
            r_bin   <= i_ops_result;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_CONV;
          end
        end
        S_CONV: begin
          r_bin <= w_bin_next;
          r_bcd <= w_bcd_next;
          r_cnt <= r_cnt + 1'b1;
          if (w_last_step) begin
            r_idx      <= '0;
            r_tx_data  <= 8'h4F;
            r_tx_valid <= 1'b1;
            r_state    <= S_SEND;
          end
        end
        S_SEND: begin
          if (w_xfer) begin
            if (r_idx == IDX_W'(LAST_IDX)) begin
              r_tx_valid <= 1'b0;
              r_tx_data  <= 8'h00;
              r_busy     <= 1'b0;
              r_state    <= S_IDLE;
            end else begin
              r_idx     <= w_next_idx;
              r_tx_data <= w_next_byte;
            end
          end
        end
        default: begin
          r_tx_valid <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  // Peak tracks every window, reported or not; drops count pulses seen while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_peak    <= '0;
      r_dropped <= 8'd0;
    end else if (i_window_done) begin
      if (i_ops_result > r_peak) r_peak <= i_ops_result;
      if (r_state != S_IDLE && r_dropped != 8'hFF) r_dropped <= r_dropped + 8'd1;
    end
  end

  assign o_tx_data       = r_tx_data;
  assign o_tx_valid      = r_tx_valid;
  assign o_busy          = r_busy;
  assign o_peak_ops      = r_peak;
  assign o_dropped_count = r_dropped;

endmodule

`default_nettype wire
